// File: rtl/teeter_pkg.sv
// Shared ADXL362 command/register constants and sequencer state type for accel_sampler.
// Optional macro ACCEL_AVG_EN adds the 4-sample mean helper.
package teeter_pkg;

   localparam logic [7:0] CMD_WR        = 8'h0A;
   localparam logic [7:0] CMD_RD        = 8'h0B;
   localparam logic [7:0] REG_XDATA     = 8'h08;
   localparam logic [7:0] REG_POWER_CTL = 8'h2D;
   localparam logic [7:0] PWR_MEASURE   = 8'h02;

   typedef enum logic [2:0] {
      INIT,
      GAP,
      WAIT_TICK,
      READ,
      UPDATE
   } state_e;

   // Byte to shift out at position idx of a transaction; read data slots send zero.
   function automatic logic [7:0] seq_byte(input logic rd, input logic [1:0] idx);
      if (rd) begin
         if (idx == 2'd0) return CMD_RD;
         if (idx == 2'd1) return REG_XDATA;
         return 8'h00;
      end
      if (idx == 2'd0) return CMD_WR;
      if (idx == 2'd1) return REG_POWER_CTL;
      return PWR_MEASURE;
   endfunction

`ifdef ACCEL_AVG_EN
   function automatic logic [7:0] mean4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
      logic signed [9:0] sum;
      logic signed [9:0] avg;
      sum = {{2{a[7]}}, a} + {{2{b[7]}}, b} + {{2{c[7]}}, c} + {{2{d[7]}}, d};
      avg = sum >>> 2;
      return avg[7:0];
   endfunction
`endif

endpackage

// File: rtl/spi_byte_xfer.sv
// One mode-0 SPI byte, full duplex, start/busy/done handshake; owns sclk and mosi.
// The first low phase is one cycle short so sclk rises CLK_DIV cycles after the start request.
module spi_byte_xfer #(
   parameter int CLK_DIV = 50
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_byte,
   output logic       sclk,
   output logic       mosi
);

   localparam int DW = $clog2(CLK_DIV + 1);

   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic [7:0]    shift_q, shift_d;
   logic [DW-1:0] div_q, div_d;
   logic [2:0]    bit_q, bit_d;

   always_comb begin
      busy_d  = busy_q;
      done_d  = 1'b0;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      shift_d = shift_q;
      div_d   = div_q;
      bit_d   = bit_q;
      if (!busy_q) begin
         if (start) begin
            busy_d  = 1'b1;
            shift_d = tx_byte;
            mosi_d  = tx_byte[7];
            sclk_d  = 1'b0;
            bit_d   = 3'd7;
            div_d   = DW'(CLK_DIV - 2);
         end
      end else if (div_q != '0) begin
         div_d = div_q - 1'b1;
      end else begin
         div_d = DW'(CLK_DIV - 1);
         if (!sclk_q) begin
            sclk_d  = 1'b1;
            shift_d = {shift_q[6:0], miso};
         end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd0) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end else begin
               bit_d  = bit_q - 1'b1;
               mosi_d = shift_q[7];
            end
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         shift_q <= '0;
         div_q   <= '0;
         bit_q   <= '0;
      end else begin
         busy_q  <= busy_d;
         done_q  <= done_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_byte = shift_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;

endmodule

// File: rtl/accel_sampler.sv
// ADXL362 tilt sampler: powers the part up once, then reads X/Y every SAMPLE_PERIOD cycles.
// Macro ACCEL_AVG_EN replaces raw outputs with the mean of the last four samples.
//
// state     | meaning
// INIT      | POWER_CTL=measure write (3 bytes, one cs_n window)
// GAP       | wait for cs_n tail, then hold cs_n high CS_GAP cycles
// WAIT_TICK | idle until the sample tick
// READ      | 0x0B 0x08 then XDATA, YDATA clocked in
// UPDATE    | one cycle: load outputs, pulse o_valid
module accel_sampler
   import teeter_pkg::*;
#(
   parameter int CLK_DIV       = 50,
   parameter int SAMPLE_PERIOD = 1666666,
   parameter int CS_GAP        = 200
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic       cs_n,
   output logic [7:0] accel_x,
   output logic [7:0] accel_y,
   output logic       o_valid
);

   localparam int TW = $clog2(SAMPLE_PERIOD);
   localparam int GW = $clog2(CS_GAP + 1);
   localparam int HW = $clog2(CLK_DIV + 1);

   state_e        state_q, state_d;
   logic          cs_n_q, cs_n_d;
   logic          start_q, start_d;
   logic [7:0]    tx_q, tx_d;
   logic [1:0]    idx_q, idx_d;
   logic          tail_q, tail_d;
   logic [HW-1:0] tail_cnt_q, tail_cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [7:0]    raw_x_q, raw_x_d;
   logic [7:0]    accel_x_q, accel_x_d;
   logic [7:0]    accel_y_q, accel_y_d;
   logic          valid_q, valid_d;
   logic          tick;

`ifdef ACCEL_AVG_EN
   logic [7:0] hx_q [3];
   logic [7:0] hx_d [3];
   logic [7:0] hy_q [3];
   logic [7:0] hy_d [3];
`endif

   logic       xfer_busy;
   logic       xfer_done;
   logic [7:0] xfer_rx;

   spi_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
      .clk_sys (CLK),
      .rst     (rst),
      .start   (start_q),
      .tx_byte (tx_q),
      .miso    (miso),
      .busy    (xfer_busy),
      .done    (xfer_done),
      .rx_byte (xfer_rx),
      .sclk    (sclk),
      .mosi    (mosi)
   );

   always_comb begin
      state_d    = state_q;
      cs_n_d     = cs_n_q;
      start_d    = 1'b0;
      tx_d       = tx_q;
      idx_d      = idx_q;
      tail_d     = tail_q;
      tail_cnt_d = tail_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      raw_x_d    = raw_x_q;
      accel_x_d  = accel_x_q;
      accel_y_d  = accel_y_q;
      valid_d    = 1'b0;
`ifdef ACCEL_AVG_EN
      hx_d = hx_q;
      hy_d = hy_q;
`endif

      tick       = (tick_cnt_q == TW'(SAMPLE_PERIOD - 1));
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

      // cs_n rises a half-period after the final sclk fall, independent of the sequencer.
      if (tail_q) begin
         if (tail_cnt_q == '0) begin
            tail_d = 1'b0;
            cs_n_d = 1'b1;
         end else begin
            tail_cnt_d = tail_cnt_q - 1'b1;
         end
      end

      case (state_q)
         INIT: begin
            if (cs_n_q) begin
               cs_n_d  = 1'b0;
               start_d = 1'b1;
               idx_d   = 2'd0;
               tx_d    = seq_byte(1'b0, 2'd0);
            end else if (xfer_done && !xfer_busy) begin
               if (idx_q == 2'd2) begin
                  state_d    = GAP;
                  idx_d      = 2'd0;
                  tail_d     = 1'b1;
                  tail_cnt_d = HW'(CLK_DIV - 2);
                  gap_cnt_d  = GW'(CS_GAP - 1);
               end else begin
                  idx_d   = idx_q + 2'd1;
                  start_d = 1'b1;
                  tx_d    = seq_byte(1'b0, idx_q + 2'd1);
               end
            end
         end
         GAP: begin
            if (cs_n_q && !tail_q) begin
               if (gap_cnt_q == '0) state_d = WAIT_TICK;
               else                 gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         WAIT_TICK: begin
            if (tick) begin
               state_d = READ;
               cs_n_d  = 1'b0;
               start_d = 1'b1;
               idx_d   = 2'd0;
               tx_d    = seq_byte(1'b1, 2'd0);
            end
         end
         READ: begin
            if (xfer_done && !xfer_busy) begin
               if (idx_q == 2'd2) raw_x_d = xfer_rx;
               if (idx_q == 2'd3) begin
                  state_d    = UPDATE;
                  tail_d     = 1'b1;
                  tail_cnt_d = HW'(CLK_DIV - 2);
               end else begin
                  idx_d   = idx_q + 2'd1;
                  start_d = 1'b1;
                  tx_d    = seq_byte(1'b1, idx_q + 2'd1);
               end
            end
         end
         UPDATE: begin
`ifdef ACCEL_AVG_EN
            accel_x_d = mean4(raw_x_q, hx_q[0], hx_q[1], hx_q[2]);
            accel_y_d = mean4(xfer_rx, hy_q[0], hy_q[1], hy_q[2]);
            hx_d[0] = raw_x_q;
            hx_d[1] = hx_q[0];
            hx_d[2] = hx_q[1];
            hy_d[0] = xfer_rx;
            hy_d[1] = hy_q[0];
            hy_d[2] = hy_q[1];
`else
            accel_x_d = raw_x_q;
            accel_y_d = xfer_rx;
`endif
            valid_d   = 1'b1;
            idx_d     = 2'd0;
            gap_cnt_d = GW'(CS_GAP - 1);
            state_d   = GAP;
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q    <= INIT;
         cs_n_q     <= 1'b1;
         start_q    <= 1'b0;
         tx_q       <= '0;
         idx_q      <= '0;
         tail_q     <= 1'b0;
         tail_cnt_q <= '0;
         gap_cnt_q  <= '0;
         tick_cnt_q <= '0;
         raw_x_q    <= '0;
         accel_x_q  <= '0;
         accel_y_q  <= '0;
         valid_q    <= 1'b0;
`ifdef ACCEL_AVG_EN
         hx_q <= '{default: '0};
         hy_q <= '{default: '0};
`endif
      end else begin
         state_q    <= state_d;
         cs_n_q     <= cs_n_d;
         start_q    <= start_d;
         tx_q       <= tx_d;
         idx_q      <= idx_d;
         tail_q     <= tail_d;
         tail_cnt_q <= tail_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         tick_cnt_q <= tick_cnt_d;
         raw_x_q    <= raw_x_d;
         accel_x_q  <= accel_x_d;
         accel_y_q  <= accel_y_d;
         valid_q    <= valid_d;
`ifdef ACCEL_AVG_EN
         hx_q <= hx_d;
         hy_q <= hy_d;
`endif
      end
   end

   assign cs_n    = cs_n_q;
   assign accel_x = accel_x_q;
   assign accel_y = accel_y_q;
   assign o_valid = valid_q;

endmodule
